// File: rtl/fifo_param.sv
// fifo_param: parametrised synchronous FIFO with occupancy, sticky error and hysteretic Pausa.
// Define FIFO_FWFT_EN for a first-word-fall-through read port; default is a registered read.
module fifo_param #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] Fifo_Data_in,
  input  logic [ADDR_WIDTH:0]   umbral_AE,
  input  logic [ADDR_WIDTH:0]   umbral_AF,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] Fifo_Data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  Fifo_Empty,
  output logic                  Fifo_Full,
  output logic                  Almost_Empty,
  output logic                  Almost_Full,
  output logic                  Pausa,
  output logic                  Error_Fifo
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_C =
    {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CNT_ONE =
    (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE =
    ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   next_count;
  logic                  pop_ok;
  logic                  push_ok;
  logic                  err_set;

  assign pop_ok  = pop & (count != '0);
  assign push_ok = push & ((count != FULL_C) | pop_ok);
  assign err_set = (push & ~push_ok) | (pop & ~pop_ok);

  always_comb begin
    next_count = count;
    unique case (1'b1)
      push_ok & ~pop_ok: next_count = count + CNT_ONE;
      pop_ok & ~push_ok: next_count = count - CNT_ONE;
      default: ;
    endcase
  end

  assign Fifo_Empty   = (count == '0);
  assign Fifo_Full    = (count == FULL_C);
  assign Almost_Empty = ~Fifo_Empty & (count <= umbral_AE);
  assign Almost_Full  = (count >= umbral_AF) & ~Fifo_Full;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= Fifo_Data_in;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      Pausa      <= 1'b0;
      Error_Fifo <= 1'b0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= next_count;
      // hysteresis: hold between the two thresholds
      if (next_count >= umbral_AF)
        Pausa <= 1'b1;
      else if (next_count <= umbral_AE)
        Pausa <= 1'b0;
      if (err_set)
        Error_Fifo <= 1'b1;
      else if (err_clr)
        Error_Fifo <= 1'b0;
    end
  end

`ifdef FIFO_FWFT_EN
  // empty FIFO shows zero so reset clears the port immediately
  assign Fifo_Data_out = Fifo_Empty ? '0 : mem[rd_ptr];
  assign valid_out     = ~Fifo_Empty;
`else
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Fifo_Data_out <= '0;
      valid_out     <= 1'b0;
    end else begin
      valid_out <= pop_ok;
      if (pop_ok)
        Fifo_Data_out <= mem[rd_ptr];
    end
  end
`endif

endmodule
